// File: rtl/dnoc_chan_seq_pkg.sv
// Shared types for the dNoC channel sequencer: FSM encoding, loop-vector type
// and the nested-loop carry helper used by both the address unit and the last-beat shadow.
package dnoc_seq_pkg;

    localparam int LOOP_N     = 4;
    localparam int SEQ_ADDR_W = 13;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_e;

    typedef logic [LOOP_N-1:0][SEQ_ADDR_W-1:0] loop_vec_t;

    // Level i steps when every inner level (i+1..LOOP_N-1) sits at its len; the innermost always steps.
    function automatic logic [LOOP_N-1:0] loop_adv(input logic [LOOP_N-1:0] at_len);
        logic [LOOP_N-1:0] adv;
        adv = '0;
        adv[LOOP_N-1] = 1'b1;
        for (int i = LOOP_N-2; i >= 0; i--) begin
            adv[i] = adv[i+1] & at_len[i+1];
        end
        return adv;
    endfunction

endpackage

// File: rtl/dnoc_chan_seq_if.sv
// Descriptor and RAM-beat bundle of one dNoC channel.
// master = the sequencer (takes descriptors, issues RAM beats); slave = the queue/arbiter side.
interface dnoc_chan_seq_if
    import dnoc_seq_pkg::*;
#(
    parameter int ADDR_W = SEQ_ADDR_W
);
    logic                           cmd_valid;
    logic                           cmd_ready;
    logic [ADDR_W-1:0]              cmd_base;
    logic [LOOP_N-1:0][ADDR_W-1:0]  cmd_gap;
    logic [LOOP_N-1:0][ADDR_W-1:0]  cmd_len;
    logic                           ram_req;
    logic [ADDR_W-1:0]              ram_addr;
    logic                           ram_gnt;

    modport master (
        input  cmd_valid, cmd_base, cmd_gap, cmd_len, ram_gnt,
        output cmd_ready, ram_req, ram_addr
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_gap, cmd_len, ram_gnt,
        input  cmd_ready, ram_req, ram_addr
    );

endinterface

// File: rtl/addr_mu.sv
// 4-level strided address generator: init loads base, each valid steps to the next address.
// Keeps one running start address per level so no multipliers are needed.
module addr_mu
    import dnoc_seq_pkg::*;
#(
    parameter int ADDR_W = SEQ_ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          initial_en,
    input  logic                          valid,
    input  logic [ADDR_W-1:0]             base,
    input  logic [LOOP_N-1:0][ADDR_W-1:0] gap,
    input  logic [LOOP_N-1:0][ADDR_W-1:0] len,
    output logic [ADDR_W-1:0]             addr
);

    logic [LOOP_N-1:0][ADDR_W-1:0] lc_q, lc_d;
    logic [LOOP_N-1:0][ADDR_W-1:0] lvl_q, lvl_d;
    logic [LOOP_N-1:0]             at_len, adv;
    logic [ADDR_W-1:0]             src;
    logic                          hit;

    always_comb begin
        for (int i = 0; i < LOOP_N; i++) begin
            at_len[i] = (lc_q[i] == len[i]);
        end
        adv   = loop_adv(at_len);
        lc_d  = lc_q;
        lvl_d = lvl_q;
        src   = '0;
        hit   = 1'b0;
        // The outermost stepping level that is not wrapping moves by its gap; all inner levels restart there.
        for (int i = 0; i < LOOP_N; i++) begin
            if (adv[i]) begin
                lc_d[i] = at_len[i] ? '0 : lc_q[i] + ADDR_W'(1);
            end
            if (!hit && adv[i] && !at_len[i]) begin
                hit = 1'b1;
                src = lvl_q[i] + gap[i];
            end
            if (hit) begin
                lvl_d[i] = src;
            end
        end
        if (!hit) begin
            lvl_d = {LOOP_N{base}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lc_q  <= '0;
            lvl_q <= '0;
        end else if (initial_en) begin
            lc_q  <= '0;
            lvl_q <= {LOOP_N{base}};
        end else if (valid) begin
            lc_q  <= lc_d;
            lvl_q <= lvl_d;
        end
    end

    assign addr = lvl_q[LOOP_N-1];

endmodule

// File: rtl/dnoc_chan_seq_loop_last.sv
// Shadow nested loop counters that track addr_mu step-for-step and flag the final beat.
module dnoc_loop_last
    import dnoc_seq_pkg::*;
#(
    parameter int ADDR_W = SEQ_ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          init,
    input  logic                          step,
    input  logic [LOOP_N-1:0][ADDR_W-1:0] len,
    output logic                          last
);

    logic [LOOP_N-1:0][ADDR_W-1:0] lc_q, lc_d;
    logic [LOOP_N-1:0]             at_len, adv;

    always_comb begin
        for (int i = 0; i < LOOP_N; i++) begin
            at_len[i] = (lc_q[i] == len[i]);
        end
        adv  = loop_adv(at_len);
        lc_d = lc_q;
        for (int i = 0; i < LOOP_N; i++) begin
            if (adv[i]) begin
                lc_d[i] = at_len[i] ? '0 : lc_q[i] + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lc_q <= '0;
        end else if (init) begin
            lc_q <= '0;
        end else if (step) begin
            lc_q <= lc_d;
        end
    end

    assign last = &at_len;

endmodule

// File: rtl/dnoc_chan_seq.sv
// Per-channel transfer sequencer: latches one strided descriptor, then issues
// one RAM request per beat through addr_mu and pulses done after the last beat.
module dnoc_chan_seq
    import dnoc_seq_pkg::*;
#(
    parameter int ADDR_W = SEQ_ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    dnoc_chan_seq_if.master   chan,
    input  logic              abort,
    input  logic              flow_ok,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  beat_cnt
);

    seq_state_e                    state_q, state_d;
    logic                          req_hold_q, req_hold_d;
    logic [ADDR_W-1:0]             base_q;
    logic [LOOP_N-1:0][ADDR_W-1:0] gap_q, len_q;

    logic              cmd_ready, ram_req, accept, beat, mu_init, last;
    logic [ADDR_W-1:0] mu_addr;

    always_comb begin
        state_d    = state_q;
        req_hold_d = req_hold_q;
        cmd_ready  = 1'b0;
        ram_req    = 1'b0;
        mu_init    = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = !abort;
                if (chan.cmd_valid && !abort) state_d = LOAD;
            end
            LOAD: begin
                mu_init = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                ram_req = flow_ok | req_hold_q;
                if (ram_req && chan.ram_gnt && last) state_d = DONE;
            end
            DONE: begin
                done    = !abort;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Once a request is shown it must persist, address unchanged, until granted.
        if (ram_req && !chan.ram_gnt) begin
            req_hold_d = 1'b1;
        end else if (chan.ram_gnt) begin
            req_hold_d = 1'b0;
        end
        if (abort && state_q != IDLE) begin
            state_d    = IDLE;
            req_hold_d = 1'b0;
        end
    end

    assign accept = chan.cmd_valid & cmd_ready;
    // A grant in an abort cycle is still a retired beat.
    assign beat   = ram_req & chan.ram_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_hold_q <= 1'b0;
            base_q     <= '0;
            gap_q      <= '0;
            len_q      <= '0;
            beat_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            req_hold_q <= req_hold_d;
            if (accept) begin
                base_q   <= chan.cmd_base;
                gap_q    <= chan.cmd_gap;
                len_q    <= chan.cmd_len;
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    addr_mu #(.ADDR_W(ADDR_W)) u_addr_mu (
        .clk        (clk),
        .rst_n      (rst_n),
        .initial_en (mu_init),
        .valid      (beat),
        .base       (base_q),
        .gap        (gap_q),
        .len        (len_q),
        .addr       (mu_addr)
    );

    dnoc_loop_last #(.ADDR_W(ADDR_W)) u_loop_last (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (mu_init),
        .step  (beat),
        .len   (len_q),
        .last  (last)
    );

    assign chan.cmd_ready = cmd_ready;
    assign chan.ram_req   = ram_req;
    assign chan.ram_addr  = mu_addr;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_dnoc_chan_seq.sv
// Directed bench for dnoc_chan_seq: single beat, 2-level stride, grant stalls,
// flow stalls, abort/restart and descriptors offered while busy or aborting.
module tb_dnoc_chan_seq;
    import dnoc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        abort, flow_ok, busy, done;
    logic [31:0] beat_cnt;
    int          n_chk  = 0;
    int          n_fail = 0;

    loop_vec_t   g0, g2, l2;
    int unsigned ea [6] = '{32'h100, 32'h101, 32'h102, 32'h110, 32'h111, 32'h112};

    dnoc_chan_seq_if #(.ADDR_W(13)) chan ();

    dnoc_chan_seq #(.ADDR_W(13), .CNT_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .chan     (chan),
        .abort    (abort),
        .flow_ok  (flow_ok),
        .busy     (busy),
        .done     (done),
        .beat_cnt (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer a descriptor, accept it, then scribble the cmd bus to prove it was latched.
    task automatic send(input logic [12:0] b, input loop_vec_t g, input loop_vec_t l);
        chan.cmd_valid = 1'b1;
        chan.cmd_base  = b;
        chan.cmd_gap   = g;
        chan.cmd_len   = l;
        #1;
        chk("cmd_ready_idle", chan.cmd_ready, 1);
        cyc();
        chan.cmd_valid = 1'b0;
        chan.cmd_base  = 13'h1abc;
        chan.cmd_gap   = '1;
        chan.cmd_len   = '0;
        #1;
        chk("load_busy", busy, 1);
        chk("load_no_req", chan.ram_req, 0);
    endtask

    // Full-rate beats through the 2-level pattern, then the done pulse.
    task automatic run_t2(input int from);
        for (int i = from; i < 6; i++) begin
            chk("t2_req", chan.ram_req, 1);
            chk("t2_addr", chan.ram_addr, ea[i]);
            chk("t2_no_done", done, 0);
            cyc();
        end
        chk("t2_done", done, 1);
        chk("t2_cnt", beat_cnt, 6);
        cyc();
        chk("t2_idle", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; abort = 1'b0; flow_ok = 1'b0;
        chan.cmd_valid = 1'b0; chan.cmd_base = '0; chan.cmd_gap = '0; chan.cmd_len = '0;
        chan.ram_gnt = 1'b0;
        g0 = '0;
        g2 = '0; g2[3] = 13'h1; g2[2] = 13'h10;
        l2 = '0; l2[3] = 13'd2; l2[2] = 13'd1;
        #12;
        chk("rst_cmd_ready", chan.cmd_ready, 1);
        chk("rst_req", chan.ram_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", beat_cnt, 0);
        rst_n = 1'b1;
        cyc();

        // T1: single beat, gnt tied high
        chan.ram_gnt = 1'b1; flow_ok = 1'b1;
        send(13'h100, g0, g0);
        cyc();
        chk("t1_req", chan.ram_req, 1);
        chk("t1_addr", chan.ram_addr, 32'h100);
        chk("t1_no_done", done, 0);
        cyc();
        chk("t1_done", done, 1);
        chk("t1_req_off", chan.ram_req, 0);
        chk("t1_cnt", beat_cnt, 1);
        cyc();
        chk("t1_done_off", done, 0);
        chk("t1_idle", busy, 0);

        // T2: 3 x 2 strided pattern
        send(13'h100, g2, l2);
        cyc();
        run_t2(0);

        // T3: beat 2 held off by gnt for 3 cycles, flow_ok dropping mid-stall
        send(13'h100, g2, l2);
        cyc();
        chk("t3_addr0", chan.ram_addr, 32'h100);
        cyc();
        chan.ram_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            flow_ok = (k == 0);
            #1;
            chk("t3_hold_req", chan.ram_req, 1);
            chk("t3_hold_addr", chan.ram_addr, 32'h101);
            cyc();
        end
        chan.ram_gnt = 1'b1; flow_ok = 1'b1;
        #1;
        run_t2(1);

        // T4: no flow, then a one-cycle flow pulse that must be held until granted
        chan.ram_gnt = 1'b0; flow_ok = 1'b0;
        send(13'h040, g0, g0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            chk("t4_no_req", chan.ram_req, 0);
            chk("t4_addr", chan.ram_addr, 32'h040);
            cyc();
        end
        flow_ok = 1'b1;
        #1;
        chk("t4_pulse_req", chan.ram_req, 1);
        cyc();
        flow_ok = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t4_held_req", chan.ram_req, 1);
            chk("t4_held_addr", chan.ram_addr, 32'h040);
            cyc();
        end
        chan.ram_gnt = 1'b1;
        #1;
        chk("t4_gnt_req", chan.ram_req, 1);
        cyc();
        chk("t4_done", done, 1);
        chk("t4_cnt", beat_cnt, 1);
        chan.ram_gnt = 1'b0;
        cyc();

        // T5: abort after beat 2, then restart at 0x200 with a clean req_hold
        chan.ram_gnt = 1'b1; flow_ok = 1'b1;
        send(13'h100, g2, l2);
        cyc();
        cyc();
        chk("t5_addr1", chan.ram_addr, 32'h101);
        cyc();
        abort = 1'b1; chan.ram_gnt = 1'b0;
        #1;
        chk("t5_abort_busy", busy, 1);
        cyc();
        abort = 1'b0;
        #1;
        chk("t5_idle", busy, 0);
        chk("t5_no_done", done, 0);
        chk("t5_cnt", beat_cnt, 2);
        chk("t5_ready", chan.cmd_ready, 1);
        flow_ok = 1'b0;
        send(13'h200, g0, g0);
        cyc();
        chk("t5_hold_clear", chan.ram_req, 0);
        chk("t5_new_addr", chan.ram_addr, 32'h200);
        flow_ok = 1'b1; chan.ram_gnt = 1'b1;
        #1;
        chk("t5_new_req", chan.ram_req, 1);
        cyc();
        chk("t5_new_done", done, 1);
        chk("t5_new_cnt", beat_cnt, 1);
        cyc();

        // T6: descriptor offered during RUN, and together with abort in IDLE
        flow_ok = 1'b0; chan.ram_gnt = 1'b0;
        send(13'h100, g2, l2);
        cyc();
        chan.cmd_valid = 1'b1; chan.cmd_base = 13'h3ff; chan.cmd_len = '0;
        #1;
        chk("t6_busy_ready", chan.cmd_ready, 0);
        cyc();
        chan.cmd_valid = 1'b0;
        flow_ok = 1'b1; chan.ram_gnt = 1'b1;
        #1;
        run_t2(0);
        abort = 1'b1; chan.cmd_valid = 1'b1; chan.cmd_base = 13'h055;
        #1;
        chk("t6_abort_ready", chan.cmd_ready, 0);
        cyc();
        chk("t6_not_taken", busy, 0);
        abort = 1'b0; chan.cmd_valid = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
